// File: rtl/cpu_multiciclo.sv
// Multi-cycle MIPS-like core: fetch, decode, execute, write-back, one state per clock.
// Small instruction memory loaded through the prog_* port while held in reset or halted.
//
// state   | meaning
// --------+------------------------------------------------------------
// BUSCA   | latch mem[pc] into the instruction register
// DECOD   | read rs/rt, sign-extend immediate; halt goes to PARADO
// EXEC    | ALU op or branch/jump; pc update; branches/NOPs return to BUSCA
// ESCRITA | register-file write and output pulse, then back to BUSCA
// PARADO  | halted until reset; instruction memory writable
module cpu_multiciclo #(
   parameter int LARGURA  = 32,
   parameter int PROF_MEM = 64,
   localparam int AP      = $clog2(PROF_MEM)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               prog_en,
   input  logic [AP-1:0]      prog_addr,
   input  logic [31:0]        prog_dado,
   output logic [LARGURA-1:0] valor_saida,
   output logic               saida_valida,
   output logic               parado,
   output logic [AP-1:0]      pc
);

   typedef enum logic [2:0] {BUSCA, DECOD, EXEC, ESCRITA, PARADO} estado_t;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_HALT = 6'h3F;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   estado_t              estado_q, estado_d;
   logic [AP-1:0]        pc_q, pc_d, pc_inc;
   logic [31:0]          ir_q, ir_d;
   logic [LARGURA-1:0]   a_q, a_d, b_q, b_d, imm_q, imm_d, res_q, res_d;
   logic [4:0]           dest_q, dest_d;
   logic [LARGURA-1:0]   valor_q, valor_d;
   logic                 valida_q, valida_d;
   logic                 rf_we;
   logic [LARGURA-1:0]   regs_q [32];
   logic [31:0]          mem_q [PROF_MEM];
   logic [5:0]           opcode, funct;

   assign opcode = ir_q[31:26];
   assign funct  = ir_q[5:0];

   // Next-state, datapath and output decode for the current state.
   always_comb begin
      estado_d = estado_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      a_d      = a_q;
      b_d      = b_q;
      imm_d    = imm_q;
      res_d    = res_q;
      dest_d   = dest_q;
      valor_d  = valor_q;
      valida_d = 1'b0;
      rf_we    = 1'b0;
      pc_inc   = pc_q + AP'(1);
      unique case (estado_q)
         BUSCA: begin
            ir_d     = mem_q[pc_q];
            estado_d = DECOD;
         end
         DECOD: begin
            a_d      = regs_q[ir_q[25:21]];
            b_d      = regs_q[ir_q[20:16]];
            imm_d    = LARGURA'($signed(ir_q[15:0]));
            estado_d = (opcode == OP_HALT) ? PARADO : EXEC;
         end
         EXEC: begin
            pc_d     = pc_inc;
            estado_d = BUSCA;
            case (opcode)
               OP_R: begin
                  dest_d = ir_q[15:11];
                  case (funct)
                     FN_ADD: begin res_d = a_q + b_q; estado_d = ESCRITA; end
                     FN_SUB: begin res_d = a_q - b_q; estado_d = ESCRITA; end
                     FN_AND: begin res_d = a_q & b_q; estado_d = ESCRITA; end
                     FN_OR:  begin res_d = a_q | b_q; estado_d = ESCRITA; end
                     FN_SLT: begin
                        res_d    = ($signed(a_q) < $signed(b_q)) ? LARGURA'(1) : '0;
                        estado_d = ESCRITA;
                     end
                     default: ;
                  endcase
               end
               OP_ADDI: begin
                  res_d    = a_q + imm_q;
                  dest_d   = ir_q[20:16];
                  estado_d = ESCRITA;
               end
               OP_BEQ: begin
                  if (a_q == b_q) pc_d = pc_inc + imm_q[AP-1:0];
               end
               OP_J: pc_d = ir_q[AP-1:0];
               default: ;
            endcase
         end
         ESCRITA: begin
            // Destination $0 still spends the cycle but produces no write or pulse.
            if (dest_q != 5'd0) begin
               rf_we    = 1'b1;
               valor_d  = res_q;
               valida_d = 1'b1;
            end
            estado_d = BUSCA;
         end
         PARADO: ;
         default: estado_d = BUSCA;
      endcase
   end

   // State, pipeline and output registers; reset aborts whatever is in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q <= BUSCA;
         pc_q     <= '0;
         ir_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         imm_q    <= '0;
         res_q    <= '0;
         dest_q   <= '0;
         valor_q  <= '0;
         valida_q <= 1'b0;
      end else begin
         estado_q <= estado_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         a_q      <= a_d;
         b_q      <= b_d;
         imm_q    <= imm_d;
         res_q    <= res_d;
         dest_q   <= dest_d;
         valor_q  <= valor_d;
         valida_q <= valida_d;
      end
   end

   // Register file; $0 is never written so it always reads zero.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      end else if (rf_we) begin
         regs_q[dest_q] <= res_q;
      end
   end

   // Instruction memory survives reset; writes only while held in reset or halted.
   always_ff @(posedge clock) begin
      if (prog_en && (reset || estado_q == PARADO)) mem_q[prog_addr] <= prog_dado;
   end

   assign valor_saida  = valor_q;
   assign saida_valida = valida_q;
   assign parado       = (estado_q == PARADO);
   assign pc           = pc_q;

endmodule
